// File: rtl/esm_issue_scheduler_if.sv
// esm_issue_scheduler_if: front-end, dependency-core, execute and flush signals of the issue scheduler
interface esm_issue_scheduler_if #(
    parameter int Instruction_word_size = 32,
    parameter int bs = 16
);
    localparam int iw = $clog2(bs);
    logic in_valid;
    logic in_ready;
    logic [Instruction_word_size-1:0] in_instr;
    logic in_regwrite;
    logic in_alusrc;
    logic [iw-1:0] ida_buffer_index;
    logic [Instruction_word_size-1:0] ida_instr;
    logic ida_regwrite;
    logic ida_alusrc;
    logic [0:bs-1] ida_valid_entries;
    logic [0:bs-1] ida_independent;
    logic issue_valid;
    logic issue_ready;
    logic [iw-1:0] issue_index;
    logic [Instruction_word_size-1:0] issue_instr;
    logic complete_valid;
    logic [iw-1:0] complete_index;
    logic flush;
    logic [iw:0] occupancy;
    modport master (
        output in_valid, in_instr, in_regwrite, in_alusrc, ida_independent, issue_ready,
               complete_valid, complete_index, flush,
        input  in_ready, ida_buffer_index, ida_instr, ida_regwrite, ida_alusrc, ida_valid_entries,
               issue_valid, issue_index, issue_instr, occupancy
    );
    modport slave (
        input  in_valid, in_instr, in_regwrite, in_alusrc, ida_independent, issue_ready,
               complete_valid, complete_index, flush,
        output in_ready, ida_buffer_index, ida_instr, ida_regwrite, ida_alusrc, ida_valid_entries,
               issue_valid, issue_index, issue_instr, occupancy
    );
endinterface

// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler: slot allocation, round-robin issue, completion and drain flush for the ESM dependency core
module esm_issue_scheduler #(
    parameter int Instruction_word_size = 32,
    parameter int bs = 16,
    parameter int IDA_LAT = 2
) (
    input logic clk,
    input logic rst,
    esm_issue_scheduler_if.slave bus
);
    localparam int iw = $clog2(bs);
    localparam int ow = iw + 1;
    localparam int aw = $clog2(IDA_LAT + 2);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_next;
    logic [0:bs-1] valid, issued, valid_next, elig, comp_clr, flush_clr;
    logic [aw-1:0] age [bs];
    logic [Instruction_word_size-1:0] mem [bs];
    logic [iw-1:0] rr_ptr, free_slot, pick;
    logic [ow-1:0] occ_next;
    logic alloc, take, hit;
    assign bus.in_ready = state == RUN && !(&valid);
    assign bus.ida_valid_entries = valid;
    assign alloc = bus.in_valid && bus.in_ready;
    assign take = bus.issue_valid && bus.issue_ready;
    always_comb begin
        state_next = state == RUN ? (bus.flush ? FLUSH : RUN) : (valid == '0 ? RUN : FLUSH);
    end
    always_comb begin
        free_slot = '0;
        pick = '0;
        hit = 1'b0;
        occ_next = '0;
        for (int i = 0; i < bs; i++) begin
            elig[i] = valid[i] && !issued[i] && age[i] == '0 && bus.ida_independent[i];
            comp_clr[i] = bus.complete_valid && bus.complete_index == iw'(i) && valid[i] && issued[i];
            // the slot under an outstanding offer survives the flush so its handshake can finish
            flush_clr[i] = state == FLUSH && valid[i] && !issued[i] && !(bus.issue_valid && bus.issue_index == iw'(i));
        end
        for (int i = bs - 1; i >= 0; i--) free_slot = valid[i] ? free_slot : iw'(i);
        for (int k = bs - 1; k >= 0; k--) begin
            pick = elig[rr_ptr + iw'(k)] ? rr_ptr + iw'(k) : pick;
            hit = hit || elig[rr_ptr + iw'(k)];
        end
        for (int i = 0; i < bs; i++) begin
            valid_next[i] = (valid[i] && !comp_clr[i] && !flush_clr[i]) || (alloc && free_slot == iw'(i));
            occ_next = occ_next + ow'(valid_next[i]);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else state <= state_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            issued <= '0;
            rr_ptr <= '0;
            bus.occupancy <= '0;
            bus.ida_buffer_index <= '0;
            bus.ida_instr <= '0;
            bus.ida_regwrite <= 1'b0;
            bus.ida_alusrc <= 1'b0;
            bus.issue_valid <= 1'b0;
            bus.issue_index <= '0;
            bus.issue_instr <= '0;
            for (int i = 0; i < bs; i++) age[i] <= '0;
        end else begin
            valid <= valid_next;
            for (int i = 0; i < bs; i++) begin
                issued[i] <= !comp_clr[i] && (issued[i] || (take && bus.issue_index == iw'(i)));
                age[i] <= alloc && free_slot == iw'(i) ? aw'(IDA_LAT) : age[i] - aw'(age[i] != '0);
            end
            bus.occupancy <= occ_next;
            bus.ida_buffer_index <= alloc ? free_slot : bus.ida_buffer_index;
            bus.ida_instr <= alloc ? bus.in_instr : '0;
            bus.ida_regwrite <= alloc && bus.in_regwrite;
            bus.ida_alusrc <= alloc && bus.in_alusrc;
            bus.issue_valid <= bus.issue_valid ? !bus.issue_ready : hit && state == RUN;
            bus.issue_index <= bus.issue_valid ? bus.issue_index : pick;
            bus.issue_instr <= bus.issue_valid ? bus.issue_instr : mem[pick];
            rr_ptr <= take ? bus.issue_index + iw'(1) : rr_ptr;
        end
    end
    always_ff @(posedge clk) begin
        if (alloc) mem[free_slot] <= bus.in_instr;
    end
endmodule
